// File: rtl/gpio_bus_arbiter.sv
// Two-master arbiter for a single GPIO-style register port: picks M0 or M1,
// runs one peripheral access cycle and returns a one-cycle ack with read data.
module gpio_bus_arbiter #(
    parameter bit RR_EN  = 1'b1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              p_cs,
    output logic              p_wr,
    output logic [ADDR_W-1:0] p_addr,
    output logic [DATA_W-1:0] p_wdata,
    input  logic [DATA_W-1:0] p_rdata,

    output logic              busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;

    logic              cmd_idx;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W-1:0] rdata_q;

    // 0 = M0 was granted last, 1 = M1 was granted last
    logic              last_grant;

    logic              any_req;
    logic              win_idx;
    logic              accept;

    // Returns 1 when M1 should win; only meaningful if at least one request is up.
    function automatic logic pick_m1(input logic r0, input logic r1, input logic last);
        if (!r0) begin
            return r1;
        end
        if (!r1) begin
            return 1'b0;
        end
        return RR_EN ? ~last : 1'b0;
    endfunction

    assign any_req = m0_req | m1_req;
    assign win_idx = pick_m1(m0_req, m1_req, last_grant);
    assign accept  = (state == ST_IDLE) && any_req;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (any_req) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state == ST_RESP) begin
                last_grant <= cmd_idx;
            end
        end
    end

    // Command is frozen at acceptance so master-side changes cannot disturb the access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_idx   <= 1'b0;
            cmd_wr    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else if (accept) begin
            cmd_idx   <= win_idx;
            cmd_wr    <= win_idx ? m1_wr    : m0_wr;
            cmd_addr  <= win_idx ? m1_addr  : m0_addr;
            cmd_wdata <= win_idx ? m1_wdata : m0_wdata;
        end
    end

    // Read data is sampled on the edge that closes ACCESS, writes included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (state == ST_ACCESS) begin
            rdata_q <= p_rdata;
        end
    end

    assign p_cs    = (state == ST_ACCESS);
    assign p_wr    = (state == ST_ACCESS) && cmd_wr;
    assign p_addr  = cmd_addr;
    assign p_wdata = cmd_wdata;

    assign m0_ack   = (state == ST_RESP) && !cmd_idx;
    assign m1_ack   = (state == ST_RESP) &&  cmd_idx;
    assign m0_rdata = rdata_q;
    assign m1_rdata = rdata_q;

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Bench for gpio_bus_arbiter: directed scenarios plus random transactions
// checked against a transaction-level model of grants, timing and memory.
module tb_gpio_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          m0_req, m0_wr, m0_ack;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_wr, m1_ack;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          p_cs, p_wr, busy;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata, p_rdata;

    // Fixed-priority instance, used for the starvation scenario
    logic          f_m0_req, f_m1_req, f_m0_ack, f_m1_ack;
    logic          f_wr;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_wdata;
    logic [DW-1:0] f_m0_rdata, f_m1_rdata;
    logic          f_p_cs, f_p_wr, f_busy;
    logic [AW-1:0] f_p_addr;
    logic [DW-1:0] f_p_wdata, f_p_rdata;

    gpio_bus_arbiter #(.RR_EN(1'b1), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .p_cs(p_cs), .p_wr(p_wr), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .busy(busy)
    );

    gpio_bus_arbiter #(.RR_EN(1'b0), .ADDR_W(AW), .DATA_W(DW)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_req(f_m0_req), .m0_wr(f_wr), .m0_addr(f_addr), .m0_wdata(f_wdata),
        .m0_ack(f_m0_ack), .m0_rdata(f_m0_rdata),
        .m1_req(f_m1_req), .m1_wr(f_wr), .m1_addr(f_addr), .m1_wdata(f_wdata),
        .m1_ack(f_m1_ack), .m1_rdata(f_m1_rdata),
        .p_cs(f_p_cs), .p_wr(f_p_wr), .p_addr(f_p_addr), .p_wdata(f_p_wdata),
        .p_rdata(f_p_rdata), .busy(f_busy)
    );

    assign f_p_rdata = f_p_addr ^ f_p_wdata;

    // Peripheral: eight word registers, combinational read, write on clock edge
    logic          mem_init;
    logic [DW-1:0] pmem [8];

    function automatic logic [DW-1:0] init_word(input int i);
        return (i == 2) ? 32'h0000_00A5 : (32'hC0DE_0000 + 32'(i));
    endfunction

    assign p_rdata = pmem[p_addr[4:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 8; i++) pmem[i] <= init_word(i);
        end else if (p_cs && p_wr) begin
            pmem[p_addr[4:2]] <= p_wdata;
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [8];
    bit            pend [2];
    logic          cwr [2];
    logic [AW-1:0] caddr [2];
    logic [DW-1:0] cwd [2];
    int            last;
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        m0_req = pend[0]; m0_wr = cwr[0]; m0_addr = caddr[0]; m0_wdata = cwd[0];
        m1_req = pend[1]; m1_wr = cwr[1]; m1_addr = caddr[1]; m1_wdata = cwd[1];
    endtask

    // One arbitration round starting in an IDLE cycle; pending masters request.
    task automatic run_round();
        int            w;
        int            ix;
        logic [DW-1:0] exp_rd;
        drive_inputs();
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_cs", p_cs, 0);
        if (!pend[0] && !pend[1]) begin
            @(posedge clk); #1;
            return;
        end
        if (pend[0] && pend[1]) w = (last == 0) ? 1 : 0;
        else                    w = pend[0] ? 0 : 1;
        @(posedge clk); #1;
        // Winner disturbs its inputs after acceptance; the access must not follow
        if (w == 0) begin
            m0_addr = caddr[0] ^ 32'h8; m0_wdata = ~cwd[0]; m0_wr = ~cwr[0];
        end else begin
            m1_addr = caddr[1] ^ 32'h8; m1_wdata = ~cwd[1]; m1_wr = ~cwr[1];
        end
        @(negedge clk);
        chk("acc_cs", p_cs, 1);
        chk("acc_wr", p_wr, cwr[w]);
        chk("acc_addr", p_addr, caddr[w]);
        chk("acc_wdata", p_wdata, cwd[w]);
        chk("acc_busy", busy, 1);
        chk("acc_noack", {m0_ack, m1_ack}, 0);
        ix = int'(caddr[w][4:2]);
        exp_rd = ref_mem[ix];
        if (cwr[w]) ref_mem[ix] = cwd[w];
        @(posedge clk); #1;
        @(negedge clk);
        chk("resp_ack0", m0_ack, (w == 0));
        chk("resp_ack1", m1_ack, (w == 1));
        chk("resp_rdata", (w == 0) ? m0_rdata : m1_rdata, exp_rd);
        chk("resp_busy", busy, 1);
        chk("resp_cs", {p_cs, p_wr}, 0);
        chk("resp_addr_hold", p_addr, caddr[w]);
        pend[w] = 0;
        last = w;
        drive_inputs();
        @(posedge clk); #1;
    endtask

    initial begin
        int k;
        int ew;
        bit ackc;
        reset = 1'b0;
        mem_init = 1'b1;
        for (int i = 0; i < 8; i++) ref_mem[i] = init_word(i);
        for (int m = 0; m < 2; m++) begin
            pend[m] = 0; cwr[m] = 0; caddr[m] = '0; cwd[m] = '0;
        end
        last = 1;
        drive_inputs();
        f_m0_req = 0; f_m1_req = 0; f_wr = 0; f_addr = 32'h4; f_wdata = 32'h0;

        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_init = 1'b0;
        @(negedge clk);
        chk("rst_cs", p_cs, 0);
        chk("rst_wr", p_wr, 0);
        chk("rst_addr", p_addr, 0);
        chk("rst_wdata", p_wdata, 0);
        chk("rst_acks", {m0_ack, m1_ack}, 0);
        chk("rst_rdata", m0_rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fp_busy", f_busy, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // M0 write of 0xFF to address 0
        pend[0] = 1; cwr[0] = 1; caddr[0] = 32'h0; cwd[0] = 32'h0000_00FF;
        run_round();

        // M1 read of address 0x8, register preloaded with 0xA5
        pend[1] = 1; cwr[1] = 0; caddr[1] = 32'h8; cwd[1] = 32'h0;
        run_round();

        // Both masters hold requests for 12 cycles straight out of reset
        reset = 1'b0;
        pend[0] = 0; pend[1] = 0;
        drive_inputs();
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst2_rdata", m1_rdata, 0);
        chk("rst2_addr", p_addr, 0);
        @(posedge clk); #1;
        cwr[0] = 0; caddr[0] = 32'h4; cwd[0] = 32'h0;
        cwr[1] = 0; caddr[1] = 32'hC; cwd[1] = 32'h0;
        pend[0] = 1; pend[1] = 1;
        drive_inputs();
        f_m0_req = 1; f_m1_req = 1;
        reset = 1'b1;
        last = 1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            k = c / 3;
            ew = k % 2;
            ackc = (c % 3 == 2);
            chk("rr_ack0", m0_ack, ackc && ew == 0);
            chk("rr_ack1", m1_ack, ackc && ew == 1);
            chk("rr_busy", busy, (c % 3 != 0));
            chk("rr_cs", p_cs, (c % 3 == 1));
            if (ackc) chk("rr_rdata", m0_rdata, ref_mem[(ew == 0) ? 1 : 3]);
            chk("fp_ack0", f_m0_ack, ackc);
            chk("fp_ack1", f_m1_ack, 0);
            chk("fp_busy", f_busy, (c % 3 != 0));
        end
        pend[0] = 0; pend[1] = 0;
        drive_inputs();
        f_m0_req = 0; f_m1_req = 0;
        last = 1;
        @(posedge clk); #1;

        // Reset asserted in the middle of an M1 access
        pend[1] = 1; cwr[1] = 0; caddr[1] = 32'h10; cwd[1] = 32'h0;
        drive_inputs();
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_pre_cs", p_cs, 1);
        reset = 1'b0;
        #1;
        chk("abort_cs", p_cs, 0);
        chk("abort_busy", busy, 0);
        chk("abort_acks", {m0_ack, m1_ack}, 0);
        @(posedge clk); #1;
        chk("abort_noack", m1_ack, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        last = 1;
        run_round();

        // Random traffic; a losing master keeps its request pending
        for (int r = 0; r < 40; r++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && $urandom_range(0, 2) != 0) begin
                    pend[m]  = 1;
                    cwr[m]   = 1'($urandom_range(0, 1));
                    caddr[m] = ($urandom() & 32'hFFFF_FFE0) | (32'($urandom_range(0, 7)) << 2);
                    cwd[m]   = $urandom();
                end
            end
            run_round();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_bus_arbiter.md
# gpio_bus_arbiter

Two-master arbiter sharing one peripheral register port (the GPIO cs/wr/addr/wdata/rdata slave interface) between the CPU load/store path (M0) and a second bus master such as a DMA or pattern sequencer (M1). It arbitrates round-robin or fixed-priority, latches the winner's command, drives exactly one peripheral access cycle and returns a one-cycle acknowledge with captured read data. It sits between the masters and the peripheral address decoder.

## Interface

- RR_EN, 1, 1 = round-robin between M0/M1; 0 = fixed priority, M0 always wins ties
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- m0_req  input  1  M0 access request, held until m0_ack
- m0_wr  input  1  M0 direction, 1 = write
- m0_addr  input  ADDR_W  M0 byte address
- m0_wdata  input  DATA_W  M0 write data
- m0_ack  output  1  one-cycle completion pulse to M0
- m0_rdata  output  DATA_W  M0 read data, valid while m0_ack = 1
- m1_req, m1_wr, m1_addr, m1_wdata, m1_ack, m1_rdata  same as M0, for M1
- p_cs  output  1  peripheral select
- p_wr  output  1  peripheral write enable
- p_addr  output  ADDR_W  peripheral address
- p_wdata  output  DATA_W  peripheral write data
- p_rdata  input  DATA_W  peripheral read data (combinational from p_addr)
- busy  output  1  1 whenever state is not IDLE

## Operation

- FSM states: IDLE, ACCESS, RESP.
- IDLE: if neither req high, stay. Otherwise choose winner; latch winner index, wr, addr, wdata into command registers; go ACCESS.
- Winner selection: only one req -> that master. Both -> RR_EN=1: master not granted last; RR_EN=0: M0.
- ACCESS (exactly one cycle): p_cs=1, p_wr/p_addr/p_wdata from command registers; peripheral write commits on the closing edge; p_rdata captured into rdata register on the same edge; go RESP.
- RESP (exactly one cycle): winner's ack=1, winner's rdata = captured value; last-grant pointer updated to winner; go IDLE.
- req inputs are ignored in ACCESS and RESP; a master keeping req high after its ack is treated as a new request in the next IDLE cycle.
- Write transactions: rdata register still loads p_rdata (value not meaningful to master).
- Outside ACCESS: p_cs=0, p_wr=0; p_addr/p_wdata hold command registers (no toggling).
- mN_rdata outputs the captured rdata register for both masters; only meaningful with corresponding ack.
- Masters must not change wr/addr/wdata while req is high and ack not yet seen; the block latches them in IDLE so later changes have no effect on the access in progress.

## Timing

- Reset (reset=0, any time, asynchronous): state=IDLE, p_cs=0, p_wr=0, p_addr=0, p_wdata=0, m0_ack=m1_ack=0, rdata register=0, busy=0, last-grant pointer=M1 (so M0 wins the first tie). Reset during ACCESS aborts the access; no ack is issued.
- Latency: req high in IDLE cycle N -> p_cs high cycle N+1 -> ack high cycle N+2 -> IDLE cycle N+3.
- Throughput: one access per 3 cycles; with both reqs held continuously and RR_EN=1, grants strictly alternate M0, M1, M0, ...
- ack is never high for both masters in the same cycle; never high for more than one cycle per access.
- busy=1 exactly in ACCESS and RESP cycles.

## Test plan

- Reset then m0 write addr=0x0, wdata=0x000000FF -> p_cs=1 with p_wr=1, p_addr=0x0, p_wdata=0xFF in cycle N+1; m0_ack pulse in N+2; m1_ack stays 0.
- m1 read addr=0x8 with p_rdata model returning 0xA5 -> m1_ack in N+2 with m1_rdata=0xA5; p_wr=0 throughout.
- RR_EN=1, both reqs held 12 cycles from reset -> 4 grants in order M0, M1, M0, M1; exactly 4 single-cycle acks.
- RR_EN=0, both reqs held continuously -> every grant to M0; m1_ack never asserted (documented starvation).
- m0_addr changed from 0x0 to 0x8 one cycle after request accepted -> p_addr=0x0 during ACCESS.
- reset driven 0 during ACCESS cycle -> p_cs drops immediately, no ack, busy=0; after release, held m1_req is served normally.
